// File: rtl/audio_note_sched.sv
// Fixed-priority scheduler that shares one square-wave tone generator among three requesters.
// Notes are timed in coarse ticks, and a one-tick silent gap follows every note that finishes.
module audio_note_sched #(
  parameter int DUR_BITS    = 8,
  parameter int TICK_CYCLES = 650000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2:0]          req,
  input  logic [4:0]          req_freq0,
  input  logic [4:0]          req_freq1,
  input  logic [4:0]          req_freq2,
  input  logic [DUR_BITS-1:0] req_dur0,
  input  logic [DUR_BITS-1:0] req_dur1,
  input  logic [DUR_BITS-1:0] req_dur2,
  output logic [2:0]          ack,
  output logic [4:0]          freq_id,
  output logic                new_f,
  output logic                mute,
  output logic                busy,
  output logic [1:0]          active_src
);

  localparam int               CNT_W    = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    tick_q, tick_d;
  logic [DUR_BITS-1:0] remaining_q, remaining_d;
  logic [4:0]          freq_q, freq_d;
  logic [1:0]          active_q, active_d;
  logic [2:0]          ack_q, ack_d;
  logic                new_f_q, new_f_d;

  logic [4:0]          src_freq [3];
  logic [DUR_BITS-1:0] src_dur  [3];
  logic [2:0]          allowed;
  logic [2:0]          eligible;

  logic                win_valid;
  logic [1:0]          win_idx;
  logic [2:0]          win_onehot;
  logic [4:0]          win_freq;
  logic [DUR_BITS-1:0] win_dur;
  logic [DUR_BITS-1:0] win_len;
  logic                tick_wrap;

  assign src_freq[0] = req_freq0;
  assign src_freq[1] = req_freq1;
  assign src_freq[2] = req_freq2;
  assign src_dur[0]  = req_dur0;
  assign src_dur[1]  = req_dur1;
  assign src_dur[2]  = req_dur2;

  // A busy generator only yields to a strictly higher source; a bit acked this cycle is stale.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_src
      assign allowed[gi]  = (state_q == ST_IDLE) || (2'(gi) > active_q);
      assign eligible[gi] = req[gi] && !ack_q[gi] && allowed[gi];
    end
  endgenerate

  always_comb begin
    win_valid  = 1'b0;
    win_idx    = 2'd0;
    win_onehot = 3'b000;
    win_freq   = '0;
    win_dur    = '0;
    for (int i = 0; i < 3; i++) begin
      if (eligible[i]) begin
        win_valid  = 1'b1;
        win_idx    = 2'(i);
        win_onehot = 3'(1 << i);
        win_freq   = src_freq[i];
        win_dur    = src_dur[i];
      end
    end
  end

  assign win_len   = (win_dur == '0) ? DUR_BITS'(1) : win_dur;
  assign tick_wrap = (tick_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_wrap ? '0 : tick_q + CNT_W'(1);
    remaining_d = remaining_q;
    freq_d      = freq_q;
    active_d    = active_q;
    ack_d       = 3'b000;
    new_f_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
      end
      ST_PLAY: begin
        if (tick_wrap) begin
          if (remaining_q <= DUR_BITS'(1)) begin
            state_d     = ST_GAP;
            remaining_d = '0;
          end else begin
            remaining_d = remaining_q - DUR_BITS'(1);
          end
        end
      end
      ST_GAP: begin
        if (tick_wrap) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tick_d  = '0;
      end
    endcase

    // An accept overrides the tick bookkeeping, so a preempt on the final PLAY cycle skips the gap.
    if (win_valid) begin
      state_d     = ST_PLAY;
      tick_d      = '0;
      remaining_d = win_len;
      freq_d      = win_freq;
      active_d    = win_idx;
      ack_d       = win_onehot;
      new_f_d     = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      remaining_q <= '0;
      freq_q      <= '0;
      active_q    <= 2'd0;
      ack_q       <= 3'b000;
      new_f_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      remaining_q <= remaining_d;
      freq_q      <= freq_d;
      active_q    <= active_d;
      ack_q       <= ack_d;
      new_f_q     <= new_f_d;
    end
  end

  assign ack        = ack_q;
  assign new_f      = new_f_q;
  assign freq_id    = freq_q;
  assign active_src = active_q;
  assign busy       = (state_q != ST_IDLE);
  assign mute       = (state_q != ST_PLAY) || (freq_q == 5'd0);

endmodule

// File: tb/tb_audio_note_sched.sv
// Scoreboard bench for audio_note_sched: an interval-based note model predicts every cycle and every accept.
module tb_audio_note_sched;

  localparam int T  = 4;
  localparam int DB = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [2:0]    req;
  logic [4:0]    r_freq [3];
  logic [DB-1:0] r_dur  [3];
  logic [2:0]    ack;
  logic [4:0]    freq_id;
  logic          new_f;
  logic          mute;
  logic          busy;
  logic [1:0]    active_src;

  audio_note_sched #(.DUR_BITS(DB), .TICK_CYCLES(T)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_freq0  (r_freq[0]),
    .req_freq1  (r_freq[1]),
    .req_freq2  (r_freq[2]),
    .req_dur0   (r_dur[0]),
    .req_dur1   (r_dur[1]),
    .req_dur2   (r_dur[2]),
    .ack        (ack),
    .freq_id    (freq_id),
    .new_f      (new_f),
    .mute       (mute),
    .busy       (busy),
    .active_src (active_src)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] ack;
    logic       new_f;
    logic       busy;
    logic       mute;
    logic [4:0] freq;
    logic [1:0] src;
  } cyc_exp_t;

  typedef struct {
    logic [1:0] src;
    logic [4:0] freq;
    int         dur;
  } acc_exp_t;

  cyc_exp_t cyc_q[$];
  acc_exp_t acc_q[$];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Model: a note accepted at edge e plays after edges [e, e+D*T) and is silent-gapped until e+(D+1)*T.
  int         edge_idx   = 0;
  int         m_play_end = 0;
  int         m_gap_end  = 0;
  logic [4:0] m_freq     = '0;
  logic [1:0] m_active   = '0;
  logic [2:0] m_ack      = '0;

  logic [2:0] pending_drop = '0;
  bit         slow_drop    = 1'b0;

  task automatic check(input bit ok, input string name, input string detail);
    chk_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // 0 = idle, 1 = playing, 2 = gap, for the state right after edge x
  function automatic int phase_at(input int x);
    if (x < m_play_end) return 1;
    if (x < m_gap_end) return 2;
    return 0;
  endfunction

  task automatic model_edge();
    int         e;
    int         st;
    int         win;
    int         d;
    logic [2:0] pend;
    cyc_exp_t   ex;
    acc_exp_t   a;
    e = edge_idx + 1;
    if (reset) begin
      m_freq     = '0;
      m_active   = '0;
      m_ack      = '0;
      m_play_end = e;
      m_gap_end  = e;
    end else begin
      st   = phase_at(edge_idx);
      pend = req & ~m_ack;
      win  = -1;
      for (int i = 0; i < 3; i++)
        if (pend[i] && (st == 0 || i > int'(m_active))) win = i;
      m_ack = '0;
      if (win >= 0) begin
        d = (int'(r_dur[win]) == 0) ? 1 : int'(r_dur[win]);
        m_freq     = r_freq[win];
        m_active   = 2'(win);
        m_ack[win] = 1'b1;
        m_play_end = e + d * T;
        m_gap_end  = m_play_end + T;
        a.src  = 2'(win);
        a.freq = r_freq[win];
        a.dur  = d;
        acc_q.push_back(a);
      end
    end
    st       = phase_at(e);
    ex.ack   = m_ack;
    ex.new_f = |m_ack;
    ex.busy  = (st != 0);
    ex.mute  = (st != 1) || (m_freq == 5'd0);
    ex.freq  = m_freq;
    ex.src   = m_active;
    cyc_q.push_back(ex);
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    edge_idx++;
    @(negedge clock);
    req = req & ~pending_drop;
    pending_drop = '0;
    for (int i = 0; i < 3; i++)
      if (m_ack[i]) begin
        if (slow_drop && $urandom_range(0, 1) == 1) pending_drop[i] = 1'b1;
        else req[i] = 1'b0;
      end
  endtask

  task automatic set_src(input int i, input int f, input int d);
    r_freq[i] = 5'(f);
    r_dur[i]  = DB'(d);
    req[i]    = 1'b1;
  endtask

  task automatic random_inputs();
    reset = ($urandom_range(0, 499) == 0);
    for (int i = 0; i < 3; i++)
      if (!req[i] && $urandom_range(0, 9) == 0) begin
        r_freq[i] = 5'($urandom_range(0, 31));
        r_dur[i]  = ($urandom_range(0, 19) == 0) ? DB'($urandom_range(0, 40))
                                                 : DB'($urandom_range(0, 4));
        req[i]    = 1'b1;
      end
  endtask

  // Monitor: one expected output set per cycle, plus one accept record per ack pulse.
  initial begin
    cyc_exp_t ex;
    acc_exp_t a;
    forever begin
      @(negedge clock);
      if (cyc_q.size() > 0) begin
        ex = cyc_q.pop_front();
        check(ack === ex.ack && new_f === ex.new_f && busy === ex.busy && mute === ex.mute &&
              freq_id === ex.freq && active_src === ex.src, "cycle",
              $sformatf("t=%0t got ack=%b new_f=%b busy=%b mute=%b freq=%0d src=%0d, need ack=%b new_f=%b busy=%b mute=%b freq=%0d src=%0d",
                        $time, ack, new_f, busy, mute, freq_id, active_src,
                        ex.ack, ex.new_f, ex.busy, ex.mute, ex.freq, ex.src));
      end
      if (ack !== 3'b000) begin
        if (acc_q.size() == 0) begin
          check(1'b0, "accept", $sformatf("t=%0t got ack=%b, need no accept", $time, ack));
        end else begin
          a = acc_q.pop_front();
          $display("accept: src %0d freq %0d dur %0d at t=%0t", a.src, a.freq, a.dur, $time);
          check(ack === (3'b001 << a.src) && freq_id === a.freq && active_src === a.src, "accept",
                $sformatf("t=%0t got ack=%b freq=%0d src=%0d, need src=%0d freq=%0d",
                          $time, ack, freq_id, active_src, a.src, a.freq));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    req   = 3'b000;
    for (int i = 0; i < 3; i++) begin
      r_freq[i] = '0;
      r_dur[i]  = '0;
    end

    // reset, then a quiet stretch
    repeat (2) step();
    reset = 1'b0;
    repeat (50) step();

    // single note
    set_src(0, 9, 3);
    repeat (20) step();

    // rest with zero duration
    set_src(1, 0, 0);
    repeat (12) step();

    // preemption of a long low-priority note
    set_src(0, 5, 10);
    repeat (7) step();
    set_src(2, 17, 2);
    repeat (60) step();

    // simultaneous requests, lower one kept pending through play and gap
    r_freq[1] = 5'd3;
    r_dur[1]  = DB'(2);
    r_freq[0] = 5'd7;
    r_dur[0]  = DB'(1);
    req       = 3'b011;
    repeat (30) step();

    // reset in the middle of a note with another request held
    set_src(0, 12, 5);
    repeat (6) step();
    set_src(1, 20, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (40) step();

    // longest duration plays in full
    set_src(2, 31, 255);
    repeat (255 * T + 10) step();

    // randomized traffic, including late request drops and occasional resets
    slow_drop = 1'b1;
    repeat (4000) begin
      random_inputs();
      step();
    end
    slow_drop = 1'b0;
    reset     = 1'b0;
    repeat (2) step();
    req = 3'b000;
    repeat (200) step();

    #1;
    check(acc_q.size() == 0, "acc_drain",
          $sformatf("got %0d expected accepts never seen, need 0", acc_q.size()));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
